counter_array: RTL

COUNTER_ARRAY -- requirements
Module: counter_array

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_chan.sv | 134 +++++++++++++
 rtl/counter_array.sv | 50 +++++
 3 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and constants for the counter_array block.
//   cnt_state_e        : per-channel FSM state (IDLE, RUN, DONE)
//   CNT_WIDTH_DEFAULT  : default counter width in bits
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int CNT_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_e;

endpackage : counter_pkg

// File: rtl/counter_chan.sv
// -----------------------------------------------------------------------------
// counter_chan
// One independent down-counter channel with one-shot and auto-reload modes.
// Configuration macro: COUNTER_RELOAD_EN (undefined -> every channel one-shot,
// reload input ignored).
// Ports:
//   clk      in   clock, all state updates on rising edge
//   rst      in   asynchronous active-low reset
//   start    in   start request, accepted only in IDLE with stop low
//   cnt_init in   load value captured on acceptance
//   reload   in   auto-reload mode, captured on acceptance
//   stop     in   abort; wins over start and terminal count
//   cnt      out  current count
//   ready    out  high while IDLE
//   done     out  one-cycle terminal-count pulse (state DONE)
// -----------------------------------------------------------------------------
module counter_chan
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cnt_init,
    input  logic             reload,
    input  logic             stop,
    output logic [WIDTH-1:0] cnt,
    output logic             ready,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    cnt_state_e       state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] init_q_r;
    logic             reload_q_r;
    logic             ready_r;
    logic             done_r;
    logic             reload_s;

`ifdef COUNTER_RELOAD_EN
    assign reload_s = reload;
`else
    // Reload mode compiled out: the captured flag is held at zero.
    assign reload_s = reload & 1'b0;
`endif

    // Channel FSM; ready/done are registered alongside the state they decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= ZERO;
            init_q_r   <= ZERO;
            reload_q_r <= 1'b0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // stop in IDLE has no effect except blocking start
                    if (start && !stop) begin
                        cnt_r      <= cnt_init;
                        init_q_r   <= cnt_init;
                        reload_q_r <= reload_s;
                        ready_r    <= 1'b0;
                        if (cnt_init != ZERO) begin
                            state_r <= RUN;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO;
                        ready_r <= 1'b1;
                        done_r  <= 1'b0;
                    end else if (cnt_r <= ONE) begin
                        // terminal count; <= also guards against a wrap from 0
                        state_r <= DONE;
                        cnt_r   <= ZERO;
                        ready_r <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        cnt_r   <= cnt_r - ONE;
                        ready_r <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    if (stop) begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO;
                        ready_r <= 1'b1;
                        done_r  <= 1'b0;
                    end else if (reload_q_r && (init_q_r != ZERO)) begin
                        // zero load value never reloads, so no zero-period loop
                        state_r <= RUN;
                        cnt_r   <= init_q_r;
                        ready_r <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO;
                        ready_r <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= ZERO;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cnt   = cnt_r;
    assign ready = ready_r;
    assign done  = done_r;

endmodule : counter_chan

// File: rtl/counter_array.sv
// -----------------------------------------------------------------------------
// counter_array
// NCH independent down-counter channels sharing one clock and reset.
// Only packing/unpacking lives here; each channel is a counter_chan.
// Configuration macro: COUNTER_RELOAD_EN (enables auto-reload mode).
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset
//   start    in   [NCH]        per-channel start request
//   cnt_init in   [NCH*WIDTH]  load values, channel i at [i*WIDTH +: WIDTH]
//   reload   in   [NCH]        per-channel auto-reload mode
//   stop     in   [NCH]        per-channel abort
//   cnt      out  [NCH*WIDTH]  counts, same packing as cnt_init
//   ready    out  [NCH]        channel idle
//   done     out  [NCH]        one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module counter_array
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       start,
    input  logic [NCH*WIDTH-1:0] cnt_init,
    input  logic [NCH-1:0]       reload,
    input  logic [NCH-1:0]       stop,
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       ready,
    output logic [NCH-1:0]       done
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        counter_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .start    (start[i]),
            .cnt_init (cnt_init[i*WIDTH +: WIDTH]),
            .reload   (reload[i]),
            .stop     (stop[i]),
            .cnt      (cnt[i*WIDTH +: WIDTH]),
            .ready    (ready[i]),
            .done     (done[i])
        );
    end

endmodule : counter_array
